// File: rtl/video_tx.sv
// rtl/video_tx.sv - serializes 24-bit pixels plus a command line onto the DVD/DVSYN/DHSYN byte port
// First-pixel fetch happens two clocks before DHSYN rises, so VBP must be at least 2.
module video_tx #(
  parameter int IW          = 640,
  parameter int IH          = 512,
  parameter int DW_DVD      = 8,
  parameter int DVD_CHN     = 3,
  parameter int VSYNC_WIDTH = 100,
  parameter int VBP         = 20,
  parameter int HBLANK      = 250,
  parameter int VFP         = 20,
  parameter int CMD_EN      = 1
) (
  input  logic                      pixel_clk,
  input  logic                      reset_l,
  input  logic                      tx_en,
  input  logic [DW_DVD*DVD_CHN-1:0] pix_dat,
  input  logic                      pix_empty,
  output logic                      pix_rdreq,
  input  logic [DW_DVD*DVD_CHN-1:0] cmd_dat,
  output logic                      cmd_rdreq,
  output logic [DW_DVD-1:0]         DVD,
  output logic                      DVSYN,
  output logic                      DHSYN,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underflow
);
  localparam int DW_LOCAL = DW_DVD * DVD_CHN;

  localparam logic [15:0] VS_LAST   = 16'(VSYNC_WIDTH - 1);
  localparam logic [15:0] VBP_LAST  = 16'(VBP - 1);
  localparam logic [15:0] VBP_FETCH = 16'(VBP - 2);
  localparam logic [15:0] ACT_LAST  = 16'(IW * DVD_CHN - 1);
  localparam logic [15:0] BLK_LAST  = 16'(HBLANK - 1);
  localparam logic [15:0] BLK_FETCH = 16'(HBLANK - 2);
  localparam logic [15:0] VFP_LAST  = 16'(VFP);
  localparam logic [15:0] LINE_LAST = 16'(IH + CMD_EN - 1);
  localparam logic [15:0] CMD_LINE  = 16'(IH);
  localparam logic [15:0] PX_LAST   = 16'(IW - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_VS, ST_VBP, ST_ACT, ST_BLK, ST_VFP} state_t;

  state_t                state, state_nxt;
  logic [15:0]           cnt, line_cnt, px;
  logic [1:0]            ph;
  logic [DW_LOCAL-1:0]   word_q, src;
  logic                  miss_q, miss_d;
  logic                  fetch_due, fetch_cmd, cur_cmd;
  logic [15:0]           fetch_line;
  logic [DW_DVD-1:0]     dvd_d;
  logic                  dvsyn_d, dhsyn_d, pix_rdreq_d, cmd_rdreq_d;
  logic                  busy_d, frame_done_d, underflow_d;

  always_ff @(posedge pixel_clk or negedge reset_l) begin
    if (!reset_l) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (tx_en)               state_nxt = ST_VS;
      ST_VS:   if (cnt == VS_LAST)      state_nxt = ST_VBP;
      ST_VBP:  if (cnt == VBP_LAST)     state_nxt = ST_ACT;
      ST_ACT:  if (cnt == ACT_LAST)     state_nxt = ST_BLK;
      ST_BLK:  if (cnt == BLK_LAST)     state_nxt = (line_cnt < LINE_LAST) ? ST_ACT : ST_VFP;
      ST_VFP:  if (cnt == VFP_LAST)     state_nxt = tx_en ? ST_VS : ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the current state and registered, so every
  // output lags the state register by exactly one clock.
  always_comb begin
    fetch_line = (state == ST_ACT) ? line_cnt :
                 (state == ST_BLK) ? line_cnt + 16'd1 : 16'd0;
    fetch_due  = (state == ST_VBP && cnt == VBP_FETCH) ||
                 (state == ST_BLK && cnt == BLK_FETCH && line_cnt < LINE_LAST) ||
                 (state == ST_ACT && ph == 2'd1 && px != PX_LAST);
    fetch_cmd  = (CMD_EN != 0) && (fetch_line == CMD_LINE);
    cur_cmd    = (CMD_EN != 0) && (line_cnt == CMD_LINE);

    pix_rdreq_d = fetch_due && !fetch_cmd && !pix_empty;
    cmd_rdreq_d = fetch_due && fetch_cmd;
    miss_d      = fetch_due ? (!fetch_cmd && pix_empty) : miss_q;

    src = miss_q ? '0 : (cur_cmd ? cmd_dat : pix_dat);
    dvd_d = '0;
    if (state == ST_ACT) begin
      case (ph)
        2'd0:    dvd_d = src[DW_DVD-1:0];
        2'd1:    dvd_d = word_q[2*DW_DVD-1:DW_DVD];
        default: dvd_d = word_q[3*DW_DVD-1:2*DW_DVD];
      endcase
    end

    dvsyn_d      = (state != ST_VS);
    dhsyn_d      = (state == ST_ACT);
    frame_done_d = (state == ST_VFP) && (cnt == VFP_LAST);
    busy_d       = (state == ST_IDLE) ? tx_en : !frame_done_d;

    underflow_d = underflow;
    if (state_nxt == ST_VS && state != ST_VS) underflow_d = 1'b0;
    else if (fetch_due && !fetch_cmd && pix_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge pixel_clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt        <= '0;
      line_cnt   <= '0;
      px         <= '0;
      ph         <= '0;
      word_q     <= '0;
      miss_q     <= 1'b0;
      DVD        <= '0;
      DVSYN      <= 1'b1;
      DHSYN      <= 1'b0;
      pix_rdreq  <= 1'b0;
      cmd_rdreq  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      cnt <= (state_nxt != state || state == ST_IDLE) ? 16'd0 : cnt + 16'd1;

      if (state == ST_VBP && state_nxt == ST_ACT)      line_cnt <= 16'd0;
      else if (state == ST_BLK && state_nxt != ST_BLK) line_cnt <= line_cnt + 16'd1;

      if (state != ST_ACT) begin
        ph <= 2'd0;
        px <= 16'd0;
      end else if (ph == 2'd2) begin
        ph <= 2'd0;
        px <= px + 16'd1;
      end else begin
        ph <= ph + 2'd1;
      end

      if (state == ST_ACT && ph == 2'd0) word_q <= src;
      miss_q     <= miss_d;
      DVD        <= dvd_d;
      DVSYN      <= dvsyn_d;
      DHSYN      <= dhsyn_d;
      pix_rdreq  <= pix_rdreq_d;
      cmd_rdreq  <= cmd_rdreq_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      underflow  <= underflow_d;
    end
  end
endmodule

// File: tb/tb_video_tx.sv
// tb/tb_video_tx.sv - randomized bench for video_tx against a frame-offset reference model
module tb_video_tx;
  localparam int IW   = 4;
  localparam int IH   = 2;
  localparam int VSW  = 5;
  localparam int VBPC = 3;
  localparam int HB   = 4;
  localparam int VFPC = 2;
  localparam int NL   = IH + 1;
  localparam int LINE = 3 * IW + HB;
  localparam int P    = VSW + VBPC + NL * LINE + VFPC + 1;

  logic        pixel_clk = 1'b0;
  logic        reset_l   = 1'b0;
  logic        tx_en     = 1'b0;
  logic        pix_empty = 1'b0;
  logic [23:0] pix_dat   = '0;
  logic [23:0] cmd_dat   = '0;
  logic        pix_rdreq, cmd_rdreq, DVSYN, DHSYN, busy, frame_done, underflow;
  logic [7:0]  DVD;

  video_tx #(
    .IW(IW), .IH(IH), .DW_DVD(8), .DVD_CHN(3), .VSYNC_WIDTH(VSW),
    .VBP(VBPC), .HBLANK(HB), .VFP(VFPC), .CMD_EN(1)
  ) dut (
    .pixel_clk(pixel_clk), .reset_l(reset_l), .tx_en(tx_en),
    .pix_dat(pix_dat), .pix_empty(pix_empty), .pix_rdreq(pix_rdreq),
    .cmd_dat(cmd_dat), .cmd_rdreq(cmd_rdreq), .DVD(DVD), .DVSYN(DVSYN),
    .DHSYN(DHSYN), .busy(busy), .frame_done(frame_done), .underflow(underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: o is the offset from the first DVSYN-low cycle; -1 is the cycle
  // before it when starting from idle, -2 is idle.
  int          o = -2;
  bit          pend, sup_cur, sup_nxt, uf_exp;
  bit          tx_en_v;
  int          empty_pct, force_miss;
  int          n_pix, n_cmd, n_done;
  logic [23:0] words [NL*IW];
  logic [23:0] serve_w;

  function automatic bit due(input int off);
    int b;
    b = off + 2 - VSW - VBPC;
    return (off >= 0) && (b >= 0) && (b < NL*LINE) && ((b % LINE) < 3*IW) && (((b % LINE) % 3) == 0);
  endfunction

  function automatic int fidx(input int off);
    int b;
    b = off + 2 - VSW - VBPC;
    return (b / LINE) * IW + (b % LINE) / 3;
  endfunction

  task automatic step();
    bit          e_vs, e_hs, e_busy, e_done, e_pr, e_cr;
    logic [23:0] wsel, w;
    logic [7:0]  e_dvd;
    int          a, idx;
    @(negedge pixel_clk);
    a      = o - VSW - VBPC;
    e_vs   = !(o >= 0 && o < VSW);
    e_hs   = (o >= 0) && (a >= 0) && (a < NL*LINE) && ((a % LINE) < 3*IW);
    e_dvd  = 8'h00;
    if (e_hs) begin
      wsel  = words[(a / LINE) * IW + (a % LINE) / 3];
      e_dvd = 8'(wsel >> (8 * ((a % LINE) % 3)));
    end
    e_busy = (o == -1) || (o >= 0 && o <= P-2);
    e_done = (o == P-1);
    if (o == -1 || (o == P-1 && pend)) uf_exp = 1'b0;
    e_pr = 1'b0;
    e_cr = 1'b0;
    if (due(o)) begin
      idx = fidx(o);
      w   = 24'($urandom);
      if (idx / IW < IH) begin
        e_pr = !sup_cur;
        words[idx] = sup_cur ? 24'h0 : w;
        if (sup_cur) uf_exp = 1'b1;
      end else begin
        e_cr = 1'b1;
        words[idx] = w;
      end
      serve_w = w;
    end

    check("DVSYN",      32'(DVSYN),      32'(e_vs));
    check("DHSYN",      32'(DHSYN),      32'(e_hs));
    check("DVD",        32'(DVD),        32'(e_dvd));
    check("busy",       32'(busy),       32'(e_busy));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("pix_rdreq",  32'(pix_rdreq),  32'(e_pr));
    check("cmd_rdreq",  32'(cmd_rdreq),  32'(e_cr));
    check("underflow",  32'(underflow),  32'(uf_exp));
    if (pix_rdreq)  n_pix++;
    if (cmd_rdreq)  n_cmd++;
    if (frame_done) n_done++;

    tx_en   = tx_en_v;
    pix_dat = (due(o-1) && fidx(o-1) / IW <  IH) ? serve_w : 24'($urandom);
    cmd_dat = (due(o-1) && fidx(o-1) / IW >= IH) ? serve_w : 24'($urandom);
    sup_nxt = 1'b0;
    if (due(o)) begin
      pix_empty = sup_cur;
    end else if (o >= 0 && o < P-1 && due(o+1) && fidx(o+1) / IW < IH) begin
      sup_nxt   = (fidx(o+1) == force_miss) || (int'($urandom_range(99)) < empty_pct);
      pix_empty = sup_nxt;
    end else begin
      pix_empty = 1'($urandom_range(1));
    end

    if (o == -2) begin
      if (tx_en_v) o = -1;
    end else if (o == -1) begin
      o = 0;
    end else if (o == P-2) begin
      pend = tx_en_v;
      o++;
    end else if (o == P-1) begin
      o = pend ? 0 : (tx_en_v ? -1 : -2);
    end else begin
      o++;
    end
    sup_cur = sup_nxt;
  endtask

  initial begin
    for (int i = 0; i < NL*IW; i++) words[i] = '0;
    empty_pct  = 0;
    force_miss = -1;
    tx_en_v    = 1'b0;
    repeat (3) step();
    reset_l = 1'b1;
    repeat (2) step();

    // Single clean frame from a one-cycle tx_en pulse.
    n_pix = 0; n_cmd = 0; n_done = 0;
    tx_en_v = 1'b1;
    step();
    tx_en_v = 1'b0;
    repeat (P + 5) step();
    check("pix_strobes", 32'(n_pix), 32'(IH * IW));
    check("cmd_strobes", 32'(n_cmd), 32'(IW));
    check("done_pulses", 32'(n_done), 32'd1);

    // Second pixel of line 0 starved; underflow must stay set while idle.
    force_miss = 1;
    tx_en_v = 1'b1;
    step();
    tx_en_v = 1'b0;
    repeat (P + 5) step();
    check("uf_sticky", 32'(underflow), 32'd1);
    force_miss = -1;

    // Back-to-back frames with random starvation, then drop tx_en in line 1.
    empty_pct = 20;
    n_done = 0;
    tx_en_v = 1'b1;
    repeat (3 * P) step();
    for (int i = 0; i < 2 * P && o != VSW + VBPC + LINE + 2; i++) step();
    tx_en_v = 1'b0;
    repeat (P + 10) step();
    check("cont_done_pulses", 32'(n_done), 32'd4);
    n_pix = 0; n_cmd = 0;
    repeat (10) step();
    check("idle_no_strobes", 32'(n_pix + n_cmd), 32'd0);

    // Asynchronous reset in the middle of an active line.
    empty_pct = 0;
    tx_en_v = 1'b1;
    step();
    tx_en_v = 1'b0;
    for (int i = 0; i < 2 * P && o != VSW + VBPC + LINE + 5; i++) step();
    @(posedge pixel_clk);
    #2 reset_l = 1'b0;
    #1;
    check("rst_DHSYN",     32'(DHSYN),      32'd0);
    check("rst_DVD",       32'(DVD),        32'd0);
    check("rst_DVSYN",     32'(DVSYN),      32'd1);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_pix_rdreq", 32'(pix_rdreq),  32'd0);
    check("rst_underflow", 32'(underflow),  32'd0);
    o = -2; pend = 1'b0; uf_exp = 1'b0; sup_cur = 1'b0;
    step();
    reset_l = 1'b1;
    tx_en_v = 1'b1;
    step();
    tx_en_v = 1'b0;
    n_done = 0;
    repeat (P + 5) step();
    check("post_rst_done", 32'(n_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
